// File: rtl/obi_ctrl_sequencer_if.sv
// OBI request/response bundle between the control sequencer (master) and the
// clock-enable/reset register block (slave).
interface obi_ctrl_sequencer_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_ctrl_sequencer.sv
// OBI initiator issuing power-up/power-down write sequences to the core clock/reset registers.
// Define CTRL_SEQ_READBACK_EN to read back and verify every write (sticky error_o on mismatch).
module obi_ctrl_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RST_DELAY = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 stop_i,
    output logic                 busy_o,
    output logic                 running_o,
    output logic                 error_o,
    obi_ctrl_sequencer_if.master obi
);

`ifdef CTRL_SEQ_READBACK_EN
    localparam bit ReadbackEn = 1'b1;
`else
    localparam bit ReadbackEn = 1'b0;
`endif
    localparam int unsigned CntW = (RST_DELAY > 0) ? $clog2(RST_DELAY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDelay} state_e;
    typedef enum logic [2:0] {StepUpW1, StepUpW2, StepUpW3, StepDnW1, StepDnW2} step_e;

    state_e          state_q, state_d;
    step_e           step_q, step_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic            pend_q, pend_d;
    logic            running_q, running_d;
    logic            error_q, error_d;
    logic [31:0]     step_addr;
    logic            step_bit;
    logic            up_phase;
    logic            stop_hit;
    logic            advance;
    logic            unused_rdata;

    assign unused_rdata = ^obi.rdata[31:1];

    always_comb begin
        step_addr = BASE_ADDR + 32'd4;
        step_bit  = 1'b0;
        case (step_q)
            StepUpW2: begin
                step_addr = BASE_ADDR;
                step_bit  = 1'b1;
            end
            StepUpW3: step_bit  = 1'b1;
            StepDnW2: step_addr = BASE_ADDR;
            default:  ;
        endcase
    end

    assign up_phase = step_q inside {StepUpW1, StepUpW2, StepUpW3};
    // A stop seen in the same cycle a step completes preempts just like a latched one.
    assign stop_hit = pend_q | stop_i;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        pend_d    = pend_q | (stop_i & up_phase & (state_q != StIdle));
        running_d = running_q;
        error_d   = error_q;
        advance   = 1'b0;

        unique case (state_q)
            StIdle: begin
                rd_d   = 1'b0;
                pend_d = 1'b0;
                if (stop_i) begin
                    step_d  = StepDnW1;
                    state_d = StReq;
                end else if (start_i) begin
                    step_d  = StepUpW1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (obi.gnt) state_d = StRsp;
            end
            StRsp: begin
                if (obi.rvalid) begin
                    if (rd_q && (obi.rdata[0] != step_bit)) begin
                        error_d   = 1'b1;
                        running_d = 1'b0;
                        pend_d    = 1'b0;
                        rd_d      = 1'b0;
                        state_d   = StIdle;
                    end else if (ReadbackEn && !rd_q && !(up_phase && stop_hit)) begin
                        rd_d    = 1'b1;
                        state_d = StReq;
                    end else begin
                        rd_d    = 1'b0;
                        advance = 1'b1;
                    end
                end
            end
            StDelay: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    state_d = StReq;
                    if (stop_hit) begin
                        pend_d = 1'b0;
                        step_d = StepDnW1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            state_d = StReq;
            if (up_phase && stop_hit) begin
                pend_d = 1'b0;
                step_d = StepDnW1;
            end else begin
                case (step_q)
                    StepUpW1: step_d = StepUpW2;
                    StepUpW2: begin
                        step_d = StepUpW3;
                        if (RST_DELAY != 0) begin
                            state_d = StDelay;
                            cnt_d   = CntW'(RST_DELAY);
                        end
                    end
                    StepUpW3: begin
                        running_d = 1'b1;
                        state_d   = StIdle;
                    end
                    StepDnW1: begin
                        running_d = 1'b0;
                        step_d    = StepDnW2;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            step_q    <= StepUpW1;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            pend_q    <= 1'b0;
            running_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            pend_q    <= pend_d;
            running_q <= running_d;
            error_q   <= error_d;
        end
    end

    assign obi.req   = (state_q == StReq);
    assign obi.addr  = obi.req ? step_addr : 32'h0;
    assign obi.we    = obi.req & ~rd_q;
    assign obi.wdata = (obi.req & ~rd_q) ? {31'b0, step_bit} : 32'h0;
    assign obi.be    = 4'hF;
    assign busy_o    = (state_q != StIdle);
    assign running_o = running_q;
    assign error_o   = ReadbackEn & error_q;

endmodule

// File: tb/tb_obi_ctrl_sequencer.sv
// Directed bench for obi_ctrl_sequencer with a small OBI register-slave model.
`timescale 1ns/1ps
module tb_obi_ctrl_sequencer;
    localparam int unsigned RstDelay = 4;
`ifdef CTRL_SEQ_READBACK_EN
    localparam bit Rb = 1'b1;
`else
    localparam bit Rb = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic busy, running, error;
    int checks = 0;
    int errors = 0;

    obi_ctrl_sequencer_if obi ();

    obi_ctrl_sequencer #(
        .BASE_ADDR(32'h0000_0000),
        .RST_DELAY(RstDelay)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start),
        .stop_i   (stop),
        .busy_o   (busy),
        .running_o(running),
        .error_o  (error),
        .obi      (obi)
    );

    always #5 clk = ~clk;

    // Slave model: configurable grant stall, rvalid one cycle after grant.
    int unsigned cyc = 0;
    int unsigned wait_cnt = 0;
    int unsigned gnt_hold = 0;
    int unsigned hold;
    bit          stall_w2 = 1'b0;
    bit          corrupt = 1'b0;
    logic        rvalid_q = 1'b0;
    logic [31:0] rdata_q = 32'h0;
    logic        clk_reg = 1'b0;
    logic        rst_reg = 1'b0;

    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_wdata[$];
    int unsigned log_hs[$];
    int unsigned log_rv[$];
    logic [31:0] exp_addr[$];
    logic        exp_we[$];
    logic [31:0] exp_wdata[$];

    always_comb begin
        hold = gnt_hold;
        if (stall_w2 && obi.addr == 32'h0 && obi.we) hold = 5;
        obi.gnt = obi.req && (wait_cnt >= hold);
    end
    assign obi.rvalid = rvalid_q;
    assign obi.rdata  = rdata_q;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rvalid_q <= obi.req && obi.gnt;
        if (!obi.req || obi.gnt) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (obi.rvalid) log_rv.push_back(cyc);
        if (obi.req && obi.gnt) begin
            log_addr.push_back(obi.addr);
            log_we.push_back(obi.we);
            log_wdata.push_back(obi.wdata);
            log_hs.push_back(cyc);
            if (obi.we) begin
                if (obi.addr == 32'h0) clk_reg <= obi.wdata[0];
                else rst_reg <= obi.wdata[0];
                rdata_q <= 32'h0;
            end else begin
                rdata_q <= {31'b0, (obi.addr == 32'h0) ? (clk_reg ^ corrupt) : rst_reg};
            end
        end
    end

    function automatic void add_exp(input logic [31:0] a, input logic d);
        exp_addr.push_back(a);
        exp_we.push_back(1'b1);
        exp_wdata.push_back({31'b0, d});
        if (Rb) begin
            exp_addr.push_back(a);
            exp_we.push_back(1'b0);
            exp_wdata.push_back(32'h0);
        end
    endfunction

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        log_hs.delete(); log_rv.delete();
        exp_addr.delete(); exp_we.delete(); exp_wdata.delete();
    endtask

    task automatic pulse(input logic s, input logic p);
        @(negedge clk);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({obi.req, obi.we, busy, running, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {obi.req, obi.we, busy, running, error});
        end
        checks++;
        if ({obi.addr, obi.wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h want 0/0", obi.addr, obi.wdata);
        end
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({obi.req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 00", {obi.req, busy});
        end
    endtask

    task automatic test_power_up();
        bit ok;
        int idx;
        clear_log();
        add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b1); add_exp(32'h4, 1'b1);
        pulse(1'b1, 1'b0);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pu_timeout: got busy want idle"); end
        checks++;
        if (log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL pu_count: got %0d want %0d", log_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if ({log_addr[i], log_we[i], log_wdata[i]} !== {exp_addr[i], exp_we[i], exp_wdata[i]}) begin
                errors++;
                $display("FAIL pu_txn%0d: got %h/%b/%h want %h/%b/%h", i, log_addr[i], log_we[i],
                         log_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
            end
        end
        idx = log_addr.size() - 1;
        if (idx >= 1 && log_rv.size() >= idx) begin
            checks++;
            if (log_hs[idx] - log_rv[idx-1] != RstDelay + 1) begin
                errors++;
                $display("FAIL pu_delay_gap: got %0d want %0d", log_hs[idx] - log_rv[idx-1],
                         RstDelay + 1);
            end
        end
        checks++;
        if ({running, busy} !== 2'b10) begin
            errors++;
            $display("FAIL pu_status: got %b want 10", {running, busy});
        end
    endtask

    task automatic test_gnt_stall();
        bit ok;
        bit found;
        clear_log();
        add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b1); add_exp(32'h4, 1'b1);
        stall_w2 = 1'b1;
        pulse(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (obi.req && obi.addr == 32'h0 && obi.we) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL stall_w2_seen: got none want W2 req"); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({obi.req, obi.addr, obi.we, obi.wdata, obi.be} !== {1'b1, 32'h0, 1'b1, 32'h1, 4'hF})
            begin
                errors++;
                $display("FAIL stall_hold%0d: got %b/%h/%b/%h/%h want 1/0/1/1/f", k, obi.req,
                         obi.addr, obi.we, obi.wdata, obi.be);
            end
            @(negedge clk);
        end
        checks++;
        if (obi.req !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", obi.req); end
        wait_idle(ok);
        stall_w2 = 1'b0;
        checks++;
        if (!ok || log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d want %0d", log_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if ({log_addr[i], log_we[i], log_wdata[i]} !== {exp_addr[i], exp_we[i], exp_wdata[i]}) begin
                errors++;
                $display("FAIL stall_txn%0d: got %h/%b/%h want %h/%b/%h", i, log_addr[i], log_we[i],
                         log_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
            end
        end
    endtask

    task automatic test_stop_in_delay();
        bit ok;
        int n_w2;
        int bad;
        clear_log();
        add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b1); add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b0);
        n_w2 = Rb ? 4 : 2;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 50 && log_addr.size() < n_w2; i++) @(negedge clk);
        pulse(1'b0, 1'b1);
        wait_idle(ok);
        checks++;
        if (!ok || log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL sd_count: got %0d want %0d", log_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if ({log_addr[i], log_we[i], log_wdata[i]} !== {exp_addr[i], exp_we[i], exp_wdata[i]}) begin
                errors++;
                $display("FAIL sd_txn%0d: got %h/%b/%h want %h/%b/%h", i, log_addr[i], log_we[i],
                         log_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
            end
        end
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] == 32'h4 && log_we[i] && log_wdata[i] == 32'h1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sd_no_release: got %0d want 0", bad); end
        checks++;
        if ({running, busy} !== 2'b00) begin
            errors++;
            $display("FAIL sd_status: got %b want 00", {running, busy});
        end
    endtask

    task automatic test_start_stop_same();
        bit ok;
        clear_log();
        add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b0);
        pulse(1'b1, 1'b1);
        wait_idle(ok);
        checks++;
        if (!ok || log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL both_count: got %0d want %0d", log_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if ({log_addr[i], log_we[i], log_wdata[i]} !== {exp_addr[i], exp_we[i], exp_wdata[i]}) begin
                errors++;
                $display("FAIL both_txn%0d: got %h/%b/%h want %h/%b/%h", i, log_addr[i], log_we[i],
                         log_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
            end
        end
        clear_log();
        add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b1); add_exp(32'h4, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_seq: got %b want 1", busy); end
        pulse(1'b1, 1'b0);
        wait_idle(ok);
        checks++;
        if (!ok || log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL busy_start_count: got %0d want %0d", log_addr.size(), exp_addr.size());
        end
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL busy_start_run: got %b want 1", running); end
    endtask

    task automatic test_async_reset();
        bit found;
        clear_log();
        gnt_hold = 100;
        pulse(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (obi.req) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ar_req_seen: got 0 want 1"); end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({obi.req, busy, running} !== 3'b000) begin
            errors++;
            $display("FAIL ar_async_drop: got %b want 000", {obi.req, busy, running});
        end
        @(negedge clk);
        rst_ni   = 1'b1;
        gnt_hold = 0;
        repeat (5) @(negedge clk);
        checks++;
        if ({obi.req, busy, running} !== 3'b000 || log_addr.size() != 0) begin
            errors++;
            $display("FAIL ar_no_resume: got %b/%0d want 000/0", {obi.req, busy, running},
                     log_addr.size());
        end
    endtask

`ifdef CTRL_SEQ_READBACK_EN
    task automatic test_readback_error();
        bit ok;
        clear_log();
        add_exp(32'h4, 1'b0); add_exp(32'h0, 1'b1);
        corrupt = 1'b1;
        pulse(1'b1, 1'b0);
        wait_idle(ok);
        corrupt = 1'b0;
        checks++;
        if (!ok || log_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL rb_count: got %0d want %0d", log_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if ({log_addr[i], log_we[i], log_wdata[i]} !== {exp_addr[i], exp_we[i], exp_wdata[i]}) begin
                errors++;
                $display("FAIL rb_txn%0d: got %h/%b/%h want %h/%b/%h", i, log_addr[i], log_we[i],
                         log_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
            end
        end
        checks++;
        if ({error, running, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rb_status: got %b want 100", {error, running, busy});
        end
    endtask
`else
    task automatic test_error_tied();
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL error_tied: got %b want 0", error); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_power_up();
        test_gnt_stall();
        test_stop_in_delay();
        test_start_stop_same();
        test_async_reset();
`ifdef CTRL_SEQ_READBACK_EN
        test_readback_error();
`else
        test_error_tied();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
